// File: rtl/mux_sync_tx.sv
// rtl/mux_sync_tx.sv - source side of a mux-synchronizer transfer: holds a word and drives a level request until acknowledged
//
// Ports:
//   clk_i        source-domain clock (only clock in the block)
//   rstn_i       asynchronous active-low reset
//   src_valid_i  upstream offers a word
//   src_data_i   offered word
//   src_ready_o  block can accept a word (IDLE and synchronized ack low)
//   data_o       registered word, stable while the destination samples it
//   sync_ctrl_o  registered level request to the destination mux synchronizer
//   ack_i        acknowledge from the destination domain (asynchronous)
//   done_o       one-cycle pulse when a four-phase handshake completes
//   err_o        one-cycle pulse on a timeout abort (always 0 without the timeout)
//   xfer_cnt_o   count of completed transfers, wraps modulo 2^16
//
// Optional feature: define MUX_SYNC_TX_TIMEOUT_EN to bound the wait in REQ and
// ACK_LO to TIMEOUT_CYCLES cycles. Without it the handshake waits indefinitely.

module mux_sync_tx #(
    parameter int DATA_WIDTH     = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  src_valid_i,
    input  logic [DATA_WIDTH-1:0] src_data_i,
    output logic                  src_ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  sync_ctrl_o,
    input  logic                  ack_i,
    output logic                  done_o,
    output logic                  err_o,
    output logic [15:0]           xfer_cnt_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_ACK_LO = 2'd2;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("mux_sync_tx: SYNC_STAGES must be 2 or greater");
        end
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout_cycles
            $error("mux_sync_tx: TIMEOUT_CYCLES must be 2 or greater");
        end
    endgenerate

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic                   ctrl_d;
    logic                   load;
    logic                   done_d;
    logic                   abort;
    logic                   ack_s;
    logic [SYNC_STAGES-1:0] ack_sync_q;

    // ack_i is asynchronous to clk_i; only the last synchronizer stage is
    // used by the control logic.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_i};
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // A stale high ack after a reset or abort holds off the next accept until
    // the destination side has dropped it.
    assign src_ready_o = (state_q == ST_IDLE) && !ack_s;

`ifdef MUX_SYNC_TX_TIMEOUT_EN
    localparam int                WAIT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_q;
    logic              err_q;

    // Counts cycles spent in the current wait state; any state change (entry
    // to REQ or ACK_LO, or return to IDLE) restarts it from zero.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wait_q <= '0;
        end else if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_q + WAIT_W'(1);
        end
    end

    // The edge that would be the TIMEOUT_CYCLES-th in the state aborts,
    // unless the normal exit condition wins on that same edge.
    assign abort = (wait_q == WAIT_LAST) &&
                   (((state_q == ST_REQ) && !ack_s) || ((state_q == ST_ACK_LO) && ack_s));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= abort;
        end
    end

    assign err_o = err_q;
`else
    assign abort = 1'b0;
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ctrl_d  = sync_ctrl_o;
        load    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (src_valid_i && src_ready_o) begin
                    load    = 1'b1;
                    ctrl_d  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    ctrl_d  = 1'b0;
                    state_d = ST_ACK_LO;
                end else if (abort) begin
                    ctrl_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_ACK_LO: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (abort) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                ctrl_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            sync_ctrl_o <= 1'b0;
            data_o      <= '0;
            done_o      <= 1'b0;
            xfer_cnt_o  <= 16'd0;
        end else begin
            state_q     <= state_d;
            sync_ctrl_o <= ctrl_d;
            done_o      <= done_d;
            // The word is captured only on accept so the destination sees a
            // stable bus for the whole handshake and afterwards.
            if (load) begin
                data_o <= src_data_i;
            end
            if (done_d) begin
                xfer_cnt_o <= xfer_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mux_sync_tx.sv
// tb/tb_mux_sync_tx.sv - directed self-checking bench for mux_sync_tx

module tb_mux_sync_tx;

    localparam int DW   = 32;
    localparam int SYNC = 2;
    localparam int TMO  = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          src_valid = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_ready;
    logic [DW-1:0] data;
    logic          sync_ctrl;
    logic          ack;
    logic          done;
    logic          err;
    logic [15:0]   xfer_cnt;

    logic          ack_manual = 1'b0;
    logic          resp_en = 1'b0;
    logic          resp_fast = 1'b0;
    logic [2:0]    ctrl_hist = '0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Destination responder: either follows sync_ctrl directly, or three
    // cycles late through a small history line.
    always @(negedge clk) ctrl_hist = {ctrl_hist[1:0], sync_ctrl};
    assign ack = ack_manual | (resp_en & (resp_fast ? sync_ctrl : ctrl_hist[2]));

    mux_sync_tx #(
        .DATA_WIDTH    (DW),
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .src_valid_i (src_valid),
        .src_data_i  (src_data),
        .src_ready_o (src_ready),
        .data_o      (data),
        .sync_ctrl_o (sync_ctrl),
        .ack_i       (ack),
        .done_o      (done),
        .err_o       (err),
        .xfer_cnt_o  (xfer_cnt)
    );

    task automatic do_reset();
        rstn = 1'b0;
        src_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (sync_ctrl !== 1'b0) begin tests_failed++; $display("FAIL reset_sync_ctrl: got %b expected 0", sync_ctrl); end
        tests_run++; if (data !== 32'h0) begin tests_failed++; $display("FAIL reset_data: got %h expected 00000000", data); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err); end
        tests_run++; if (xfer_cnt !== 16'h0) begin tests_failed++; $display("FAIL reset_cnt: got %h expected 0000", xfer_cnt); end
        rstn = 1'b1;
        @(negedge clk);
        tests_run++; if (src_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_first_edge: got %b expected 1", src_ready); end
    endtask

    task automatic test_single_word();
        int dones;
        int errs;
        dones = 0;
        errs = 0;
        do_reset();
        resp_en = 1'b1;
        resp_fast = 1'b0;
        src_data = 32'hDEADBEEF;
        src_valid = 1'b1;
        @(negedge clk);
        src_valid = 1'b0;
        src_data = '0;
        tests_run++; if (sync_ctrl !== 1'b1) begin tests_failed++; $display("FAIL single_req_raised: got %b expected 1", sync_ctrl); end
        for (int c = 0; c < 30; c++) begin
            tests_run++; if (data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL single_data_hold: cycle %0d got %h expected deadbeef", c, data); end
            if (done) dones++;
            if (err) errs++;
            @(negedge clk);
        end
        tests_run++; if (dones != 1) begin tests_failed++; $display("FAIL single_done_pulses: got %0d expected 1", dones); end
        tests_run++; if (errs != 0) begin tests_failed++; $display("FAIL single_err_pulses: got %0d expected 0", errs); end
        tests_run++; if (xfer_cnt !== 16'd1) begin tests_failed++; $display("FAIL single_cnt: got %0d expected 1", xfer_cnt); end
        tests_run++; if (sync_ctrl !== 1'b0) begin tests_failed++; $display("FAIL single_req_dropped: got %b expected 0", sync_ctrl); end
        resp_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int idx;
        int got;
        bit inflight;
        bit acc;
        logic [31:0] last;
        idx = 0;
        got = 0;
        inflight = 1'b0;
        last = '0;
        do_reset();
        resp_en = 1'b1;
        resp_fast = 1'b0;
        src_valid = 1'b1;
        src_data = 32'hC0DE0000;
        for (int c = 0; c < 400 && got < 10; c++) begin
            acc = src_ready && src_valid;
            tests_run++; if (acc && inflight) begin tests_failed++; $display("FAIL b2b_accept_busy: ready %b while word %0d in flight, expected 0", src_ready, idx - 1); end
            @(negedge clk);
            if (acc) begin
                tests_run++; if (data !== 32'hC0DE0000 + idx) begin tests_failed++; $display("FAIL b2b_data: got %h expected %h", data, 32'hC0DE0000 + idx); end
                last = 32'hC0DE0000 + idx;
                idx++;
                inflight = 1'b1;
                if (idx < 10) src_data = 32'hC0DE0000 + idx;
                else src_valid = 1'b0;
            end else begin
                tests_run++; if (data !== last) begin tests_failed++; $display("FAIL b2b_data_hold: got %h expected %h", data, last); end
            end
            if (done) begin
                got++;
                inflight = 1'b0;
            end
        end
        src_valid = 1'b0;
        tests_run++; if (got != 10) begin tests_failed++; $display("FAIL b2b_done_count: got %0d expected 10", got); end
        tests_run++; if (idx != 10) begin tests_failed++; $display("FAIL b2b_accept_count: got %0d expected 10", idx); end
        tests_run++; if (xfer_cnt !== 16'd10) begin tests_failed++; $display("FAIL b2b_cnt: got %0d expected 10", xfer_cnt); end
        resp_en = 1'b0;
    endtask

    task automatic test_sync_hold();
        int hi;
        int dones;
        hi = 1;
        dones = 0;
        do_reset();
        resp_en = 1'b1;
        resp_fast = 1'b1;
        src_data = 32'h13579BDF;
        src_valid = 1'b1;
        @(negedge clk);
        src_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dones++;
            if (sync_ctrl) hi++;
            else break;
        end
        tests_run++; if (hi < SYNC + 1) begin tests_failed++; $display("FAIL hold_req_cycles: got %0d expected at least %0d", hi, SYNC + 1); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        tests_run++; if (dones != 1) begin tests_failed++; $display("FAIL hold_done_pulses: got %0d expected 1", dones); end
        tests_run++; if (xfer_cnt !== 16'd1) begin tests_failed++; $display("FAIL hold_cnt: got %0d expected 1", xfer_cnt); end
        resp_en = 1'b0;
        resp_fast = 1'b0;
    endtask

    task automatic test_reset_ack_high();
        int spurious;
        spurious = 0;
        resp_en = 1'b0;
        ack_manual = 1'b1;
        src_valid = 1'b0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        tests_run++; if (src_ready !== 1'b1) begin tests_failed++; $display("FAIL ackhi_ready_edge1: got %b expected 1", src_ready); end
        @(negedge clk);
        tests_run++; if (src_ready !== 1'b0) begin tests_failed++; $display("FAIL ackhi_ready_blocked: got %b expected 0", src_ready); end
        src_data = 32'h12345678;
        src_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (sync_ctrl || done || err || src_ready) spurious++;
        end
        tests_run++; if (spurious != 0) begin tests_failed++; $display("FAIL ackhi_no_accept: got %0d active cycles expected 0", spurious); end
        ack_manual = 1'b0;
        @(negedge clk);
        tests_run++; if (src_ready !== 1'b0) begin tests_failed++; $display("FAIL ackhi_ready_sync_lag: got %b expected 0", src_ready); end
        @(negedge clk);
        src_valid = 1'b0;
        tests_run++; if (src_ready !== 1'b1) begin tests_failed++; $display("FAIL ackhi_ready_release: got %b expected 1", src_ready); end
        tests_run++; if (data !== 32'h0) begin tests_failed++; $display("FAIL ackhi_data: got %h expected 00000000", data); end
        tests_run++; if (xfer_cnt !== 16'd0) begin tests_failed++; $display("FAIL ackhi_cnt: got %0d expected 0", xfer_cnt); end
    endtask

    task automatic test_reset_mid_req();
        int pulses;
        pulses = 0;
        do_reset();
        resp_en = 1'b0;
        ack_manual = 1'b0;
        src_data = 32'hFEEDFACE;
        src_valid = 1'b1;
        @(negedge clk);
        src_valid = 1'b0;
        tests_run++; if (sync_ctrl !== 1'b1) begin tests_failed++; $display("FAIL midreq_req_raised: got %b expected 1", sync_ctrl); end
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        tests_run++; if (sync_ctrl !== 1'b0) begin tests_failed++; $display("FAIL midreq_async_ctrl: got %b expected 0", sync_ctrl); end
        tests_run++; if (src_ready !== 1'b1) begin tests_failed++; $display("FAIL midreq_idle: ready got %b expected 1", src_ready); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL midreq_done: got %b expected 0", done); end
        tests_run++; if (xfer_cnt !== 16'd0) begin tests_failed++; $display("FAIL midreq_cnt: got %0d expected 0", xfer_cnt); end
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || err || sync_ctrl) pulses++;
        end
        tests_run++; if (pulses != 0) begin tests_failed++; $display("FAIL midreq_after_release: got %0d active cycles expected 0", pulses); end
    endtask

    task automatic test_timeout();
        int err_at;
        int err_cycles;
        err_at = -1;
        err_cycles = 0;
        do_reset();
        resp_en = 1'b0;
        ack_manual = 1'b0;
        src_data = 32'h0BADF00D;
        src_valid = 1'b1;
        @(negedge clk);
        src_valid = 1'b0;
        tests_run++; if (sync_ctrl !== 1'b1) begin tests_failed++; $display("FAIL tmo_req_raised: got %b expected 1", sync_ctrl); end
`ifdef MUX_SYNC_TX_TIMEOUT_EN
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (err) begin
                err_cycles++;
                if (err_at < 0) err_at = k;
            end
            if (k == TMO - 1) begin
                tests_run++; if (sync_ctrl !== 1'b1) begin tests_failed++; $display("FAIL tmo_req_before_limit: got %b expected 1", sync_ctrl); end
            end
        end
        tests_run++; if (err_at != TMO) begin tests_failed++; $display("FAIL tmo_err_cycle: got %0d expected %0d", err_at, TMO); end
        tests_run++; if (err_cycles != 1) begin tests_failed++; $display("FAIL tmo_err_width: got %0d expected 1", err_cycles); end
        tests_run++; if (sync_ctrl !== 1'b0) begin tests_failed++; $display("FAIL tmo_ctrl: got %b expected 0", sync_ctrl); end
        tests_run++; if (src_ready !== 1'b1) begin tests_failed++; $display("FAIL tmo_idle: ready got %b expected 1", src_ready); end
        tests_run++; if (xfer_cnt !== 16'd0) begin tests_failed++; $display("FAIL tmo_cnt: got %0d expected 0", xfer_cnt); end
`else
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (err) err_cycles++;
        end
        tests_run++; if (err_cycles != 0) begin tests_failed++; $display("FAIL notmo_err: got %0d expected 0", err_cycles); end
        tests_run++; if (sync_ctrl !== 1'b1) begin tests_failed++; $display("FAIL notmo_still_waiting: got %b expected 1", sync_ctrl); end
        tests_run++; if (err_at != -1) begin tests_failed++; $display("FAIL notmo_err_at: got %0d expected -1", err_at); end
`endif
        do_reset();
    endtask

    task automatic test_wrap();
        int got;
        got = 0;
        do_reset();
        resp_en = 1'b1;
        resp_fast = 1'b1;
        src_data = 32'h5A5A5A5A;
        src_valid = 1'b1;
        for (int c = 0; c < 65535 * 8 && got < 65535; c++) begin
            @(negedge clk);
            if (done) got++;
        end
        tests_run++; if (got != 65535) begin tests_failed++; $display("FAIL wrap_done_count: got %0d expected 65535", got); end
        tests_run++; if (xfer_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_cnt_max: got %h expected ffff", xfer_cnt); end
        for (int c = 0; c < 50 && got < 65536; c++) begin
            @(negedge clk);
            if (done) begin
                got++;
                src_valid = 1'b0;
            end
        end
        src_valid = 1'b0;
        tests_run++; if (got != 65536) begin tests_failed++; $display("FAIL wrap_last_done: got %0d expected 65536", got); end
        tests_run++; if (xfer_cnt !== 16'h0000) begin tests_failed++; $display("FAIL wrap_cnt_zero: got %h expected 0000", xfer_cnt); end
        resp_en = 1'b0;
        resp_fast = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_sync_hold();
        test_reset_ack_high();
        test_reset_mid_req();
        test_timeout();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mux_sync_tx.md
MUX_SYNC_TX -- requirements
Module: mux_sync_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the width of the transferred data bus.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, legal values 2 or greater, meaning the flop depth of the internal ack synchronizer.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, legal values 2 or greater, meaning the wait limit used only when MUX_SYNC_TX_TIMEOUT_EN is defined.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the source-domain clock, which is the only clock in the block.
REQ-005 The block SHALL have port rstn_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port src_valid_i, input, 1 bit: upstream offers a word.
REQ-007 The block SHALL have port src_data_i, input, DATA_WIDTH bits: the offered word.
REQ-008 The block SHALL have port src_ready_o, output, 1 bit: the block can accept a word.
REQ-009 The block SHALL have port data_o, output, DATA_WIDTH bits: the registered word held stable for the destination mux synchronizer.
REQ-010 The block SHALL have port sync_ctrl_o, output, 1 bit: registered level request to the destination-domain mux synchronizer.
REQ-011 The block SHALL have port ack_i, input, 1 bit: acknowledge from the destination domain, asynchronous to clk_i.
REQ-012 The block SHALL have port done_o, output, 1 bit: one-cycle pulse when a handshake completes.
REQ-013 The block SHALL have port err_o, output, 1 bit: one-cycle pulse when a timeout abort occurs.
REQ-014 The block SHALL have port xfer_cnt_o, output, 16 bits: count of completed transfers.

Function
REQ-015 ack_i SHALL pass through SYNC_STAGES flops clocked by clk_i; the last stage is ack_s, and no other logic SHALL sample ack_i directly.
REQ-016 The state machine SHALL have three states: IDLE, REQ and ACK_LO.
REQ-017 src_ready_o SHALL be 1 only when the state is IDLE and ack_s is 0.
REQ-018 In IDLE, on a clock edge with src_valid_i=1 and src_ready_o=1, the block SHALL load src_data_i into data_o, set sync_ctrl_o to 1, and enter REQ.
REQ-019 data_o SHALL change only on an accept edge and SHALL hold its value through REQ and ACK_LO and after return to IDLE.
REQ-020 In REQ, on the first edge where ack_s is 1, the block SHALL clear sync_ctrl_o and enter ACK_LO; otherwise it SHALL hold REQ.
REQ-021 In ACK_LO, on the first edge where ack_s is 0, the block SHALL enter IDLE, pulse done_o for exactly 1 cycle, and increment xfer_cnt_o.
REQ-022 xfer_cnt_o SHALL increment modulo 2^16, wrapping from 0xFFFF to 0x0000.
REQ-023 The block SHALL ignore src_valid_i outside IDLE and SHALL NOT buffer a second word.
REQ-024 A stale ack_s=1 seen in IDLE SHALL only block accept (through src_ready_o) and SHALL NOT cause a state change.
REQ-025 With ack_i asserted at the edge following accept, sync_ctrl_o SHALL stay high for at least SYNC_STAGES+1 cycles.

Reset
REQ-026 On rstn_i=0 the block SHALL asynchronously set: state IDLE, sync_ctrl_o 0, data_o 0, done_o 0, err_o 0, xfer_cnt_o 0, all synchronizer flops 0, timeout counter 0.
REQ-027 A reset asserted in REQ or ACK_LO SHALL abort the transfer immediately, with no done_o or err_o pulse.
REQ-028 After rstn_i deasserts, src_ready_o SHALL be 1 from the first edge.

Configuration
REQ-029 When macro MUX_SYNC_TX_TIMEOUT_EN is defined, the block SHALL contain a wait counter that clears on entry to REQ and on entry to ACK_LO.
REQ-030 With MUX_SYNC_TX_TIMEOUT_EN defined, if the block spends TIMEOUT_CYCLES cycles in REQ or in ACK_LO without the exit condition, it SHALL clear sync_ctrl_o, enter IDLE, pulse err_o for 1 cycle, and leave xfer_cnt_o unchanged.
REQ-031 When MUX_SYNC_TX_TIMEOUT_EN is undefined, the counter SHALL be absent, err_o SHALL be tied to 0, and REQ and ACK_LO SHALL wait indefinitely.

Verification
REQ-032 The bench SHALL cover: offer 0xDEADBEEF; responder raises ack_i 3 cycles after sync_ctrl_o=1 and lowers it 3 cycles after sync_ctrl_o=0 -> data_o=0xDEADBEEF throughout, one done_o pulse, xfer_cnt_o=1.
REQ-033 The bench SHALL cover: src_valid_i held high with 10 back-to-back words -> each word is accepted only in IDLE, received in order with none lost, and xfer_cnt_o=10.
REQ-034 The bench SHALL cover: ack_i held at 1 during reset release -> src_ready_o=0 until ack_s falls, and there is no spurious transfer.
REQ-035 The bench SHALL cover: rstn_i pulsed low mid-REQ -> sync_ctrl_o=0 asynchronously, state IDLE, xfer_cnt_o=0, done_o=0.
REQ-036 The bench SHALL cover: MUX_SYNC_TX_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, ack_i never asserted -> err_o pulses 8 cycles after REQ entry, sync_ctrl_o=0, xfer_cnt_o unchanged.
REQ-037 The bench SHALL cover: xfer_cnt_o preloaded by running 65536 transfers -> xfer_cnt_o wraps to 0x0000.
